regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Owns the single write port (WE3/AD3/WD3) of the register file.
//  - Arbitrates between two writeback sources: src0 = ALU result, src1 = load/memory data.
//  - Uses valid/ready handshakes and round-robin priority.
//  - Suppresses writes to x0.
//  - Can optionally zero the whole register file after reset before normal operation.
// PARAMETERS
//  ADDRESS_WIDTH  5   register index width (2**ADDRESS_WIDTH registers)
//  DATA_WIDTH     32  register data width
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      synchronous, active-high reset
//  req0_valid  in   1      src0 has a write pending
//  req0_addr   in   AW     src0 destination register
//  req0_data   in   DW     src0 write data
//  req0_ready  out  1      src0 request accepted this cycle
//  req1_valid  in   1      src1 has a write pending
//  req1_addr   in   AW     src1 destination register
//  req1_data   in   DW     src1 write data
//  req1_ready  out  1      src1 request accepted this cycle
//  WE3         out  1      register file write enable
//  AD3         out  AW     register file write address
//  WD3         out  DW     register file write data
//  busy        out  1      clear sequence in progress
// BEHAVIOUR
//  - Reset (rst=1 at a clock edge):
//    - WE3=0, AD3=0, WD3=0, req*_ready=0, rr_ptr=0.
//    - state=CLEAR, clr_cnt=1.
//    - Reset mid-operation aborts everything; nothing accepted earlier is re-issued.
//  - FSM states: CLEAR, RUN.
//    - CLEAR:
//      - Each cycle registers WE3=1, AD3=clr_cnt, WD3=0; clr_cnt increments.
//      - busy=1; both ready outputs are 0.
//      - After address 2**AW-1 is written, go to RUN (31 write cycles when AW=5).
//    - RUN: busy=0.
//  - Handshake:
//    - A transfer occurs when valid & ready are both high in the same cycle.
//    - A source holds valid/addr/data stable until it is accepted.
//    - ready is combinational from the valid inputs, state and rr_ptr. At most one ready is high per cycle.
//  - Arbitration (RUN state):
//    - Only one source valid: that source is granted.
//    - Both valid: source rr_ptr is granted.
//    - After any grant, rr_ptr = ~granted_src. Neither source waits more than 1 cycle under contention.
//  - Write path:
//    - Latency: the granted request appears on WE3/AD3/WD3 on the cycle after acceptance. Outputs are registered.
//    - WE3=1 for one cycle per accepted request, except addr==0: the request is accepted but WE3=0.
//    - No grant in a cycle: WE3=0 on the next cycle, and AD3/WD3 hold their previous values.
//  - Same address from both sources in one cycle: serialised by arbitration; the later grant's data is final.
// CONFIGURATION
//  REGFILE_CLEAR_EN
//   - Defined: CLEAR sequence runs after every reset, as described above.
//   - Undefined: reset goes straight to RUN; busy is tied to 0; clr_cnt logic is not built.
//     The first cycle after reset deasserts can already accept a request.
// STRUCTURE
//  - Package regfile_pkg:
//    - REG_AW=5, REG_DW=32 constants.
//    - typedef enum logic {WB_CLEAR, WB_RUN} wb_state_t.
//    - typedef enum logic {SRC_ALU=0, SRC_MEM=1} wb_src_t.
//  - Sub-module rr_arb2: 2-requester round-robin arbiter.
//    - Inputs: clk, rst, req[1:0], enable.
//    - Outputs: grant[1:0] (one-hot or zero).
//    - rr_ptr lives inside rr_arb2.
//  - Top level holds the FSM, clr_cnt, x0 suppression and the output registers.
// TESTING
//  1. Clear (REGFILE_CLEAR_EN defined): pulse rst for 1 cycle.
//     -> busy=1 for 31 cycles; WE3=1 with AD3=1..31 and WD3=0; then busy=0, ready enabled.
//  2. Single write: req0 valid, addr=5, data=0xDEADBEEF.
//     -> req0_ready=1 that cycle; next cycle WE3=1, AD3=5, WD3=0xDEADBEEF.
//  3. Contention: both sources valid for 4 cycles, src0 addr=3, src1 addr=7, rr_ptr=0.
//     -> grant order src0, src1, src0, src1; AD3 = 3,7,3,7 one cycle later.
//  4. x0 write: req1 valid, addr=0, data=0x1234.
//     -> req1_ready=1; WE3 remains 0 on the following cycle.
//  5. Reset mid-clear: assert rst when AD3=10.
//     -> clear restarts at AD3=1; full 31-cycle sequence is observed.
//  6. Same address: src0 {9,0xA}, src1 {9,0xB} valid together, rr_ptr=0.
//     -> WE3 writes 9<=0xA, then 9<=0xB; final register value 0xB.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register-file writeback arbiter.
//   REG_AW / REG_DW : default register index / data widths
//   wb_state_t      : writeback controller state (clear sequence or normal run)
//   wb_src_t        : writeback source identifier (ALU result or memory data)
package regfile_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned REG_DW = 32;

    typedef enum logic {WB_CLEAR, WB_RUN} wb_state_t;

    typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} wb_src_t;

endpackage : regfile_pkg

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the two writeback sources, the arbiter and the register
// file write port.
//   req0_*      : src0 (ALU) valid/addr/data in, ready out
//   req1_*      : src1 (MEM) valid/addr/data in, ready out
//   WE3/AD3/WD3 : register file write enable / address / data
//   busy        : clear sequence in progress
// Modports: master = sources + register file side, slave = arbiter side.
interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int unsigned AW = REG_AW,
    parameter int unsigned DW = REG_DW
);

    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req0_ready;

    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          req1_ready;

    logic          WE3;
    logic [AW-1:0] AD3;
    logic [DW-1:0] WD3;
    logic          busy;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  WE3, AD3, WD3, busy
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output WE3, AD3, WD3, busy
    );

endinterface : regfile_wb_arbiter_if

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, rst  : clock, synchronous active-high reset
//   req_i     : request vector, bit n = requester n
//   enable_i  : grants are only issued while high
//   grant_c   : combinational grant, one-hot or zero
// The pointer names the requester that wins the next tie; after any grant it
// moves to the other requester, so a loser never waits more than one cycle.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       enable_i,
    output logic [1:0] grant_c
);

    logic rr_ptr_q;
    logic rr_ptr_d;

    // Grant selection and pointer update
    always_comb begin
        grant_c  = 2'b00;
        rr_ptr_d = rr_ptr_q;
        if (enable_i) begin
            case (req_i)
                2'b01:   grant_c = 2'b01;
                2'b10:   grant_c = 2'b10;
                2'b11:   grant_c = rr_ptr_q ? 2'b10 : 2'b01;
                default: grant_c = 2'b00;
            endcase
        end
        if (grant_c[0]) begin
            rr_ptr_d = 1'b1;
        end else if (grant_c[1]) begin
            rr_ptr_d = 1'b0;
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule : rr_arb2

// File: rtl/regfile_wb_arbiter.sv
// Owner of the register file write port (WE3/AD3/WD3). Arbitrates ALU (src0)
// and memory (src1) writebacks round-robin, drops writes to x0 after
// accepting them, and registers the winning write one cycle after acceptance.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of regfile_wb_arbiter_if (requests, ready, write port, busy)
// Build option REGFILE_CLEAR_EN: when defined, every reset is followed by a
// sequence writing zero to registers 1..2**AW-1 (busy high, ready low) before
// normal operation; when undefined, requests are accepted right after reset.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = REG_AW,
    parameter int unsigned DATA_WIDTH    = REG_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int unsigned AW = ADDRESS_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;

    logic [1:0]    grant;
    logic          arb_en;
    logic          clearing;
    logic [AW-1:0] clr_addr;
    wb_src_t       sel_src;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    logic          we_q, we_d;
    logic [AW-1:0] ad_q, ad_d;
    logic [DW-1:0] wd_q, wd_d;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    ({bus.req1_valid, bus.req0_valid}),
        .enable_i (arb_en),
        .grant_c  (grant)
    );

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];

`ifdef REGFILE_CLEAR_EN
    wb_state_t     state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;

    // State and clear counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WB_CLEAR;
            clr_cnt_q <= AW'(1);
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next state: leave CLEAR once the top register index has been issued
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            WB_CLEAR: begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == {AW{1'b1}}) begin
                    state_d = WB_RUN;
                end
            end
            WB_RUN: begin
                state_d = WB_RUN;
            end
        endcase
    end

    assign clearing = (state_q == WB_CLEAR);
    assign clr_addr = clr_cnt_q;
`else
    assign clearing = 1'b0;
    assign clr_addr = '0;
`endif

    assign arb_en   = ~clearing;
    assign bus.busy = clearing;

    // Route the granted source onto the write path
    assign sel_src  = grant[1] ? SRC_MEM : SRC_ALU;
    assign sel_addr = (sel_src == SRC_MEM) ? bus.req1_addr : bus.req0_addr;
    assign sel_data = (sel_src == SRC_MEM) ? bus.req1_data : bus.req0_data;

    // Write-port next value; x0 requests are consumed without a write strobe
    always_comb begin
        we_d = 1'b0;
        ad_d = ad_q;
        wd_d = wd_q;
        if (clearing) begin
            we_d = 1'b1;
            ad_d = clr_addr;
            wd_d = '0;
        end else if (|grant) begin
            we_d = (sel_addr != '0);
            ad_d = sel_addr;
            wd_d = sel_data;
        end
    end

    // Write-port output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q <= 1'b0;
            ad_q <= '0;
            wd_q <= '0;
        end else begin
            we_q <= we_d;
            ad_q <= ad_d;
            wd_q <= wd_d;
        end
    end

    assign bus.WE3 = we_q;
    assign bus.AD3 = ad_q;
    assign bus.WD3 = wd_q;

endmodule : regfile_wb_arbiter
